// File: rtl/shiftregister_framed_if.sv
// Bus between the SPI control FSM (master) and the framed shift register (slave).
// Carries parallel/serial data, shift/load strobes and frame status.
interface shiftregister_framed_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    logic             peripheralClkEdge;
    logic             parallelLoad;
    logic [WIDTH-1:0] parallelDataIn;
    logic             serialDataIn;
    logic             lsbFirst;
    logic             frameStart;
    logic [WIDTH-1:0] parallelDataOut;
    logic             serialDataOut;
    logic [CNTW-1:0]  bitCount;
    logic             frameDone;
    logic             frameValid;

    modport master (
        output peripheralClkEdge, parallelLoad, parallelDataIn, serialDataIn, lsbFirst,
               frameStart,
        input  parallelDataOut, serialDataOut, bitCount, frameDone, frameValid
    );

    modport slave (
        input  peripheralClkEdge, parallelLoad, parallelDataIn, serialDataIn, lsbFirst,
               frameStart,
        output parallelDataOut, serialDataOut, bitCount, frameDone, frameValid
    );
endinterface

// File: rtl/shiftregister_framed.sv
// WIDTH-bit shift register with parallel load, runtime MSB/LSB-first shifting,
// a per-frame bit counter and frame-complete pulse/level.
module shiftregister_framed #(
    parameter int unsigned WIDTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    shiftregister_framed_if.slave bus
);
    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic [CNTW-1:0]  cnt_base;
    logic [CNTW-1:0]  cnt_inc;

    // frameStart restarts counting from zero even when it coincides with a shift
    assign cnt_base = bus.frameStart ? '0 : cnt_q;
    assign cnt_inc  = cnt_base + 1'b1;

    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        if (bus.parallelLoad) begin
            sreg_d  = bus.parallelDataIn;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (bus.peripheralClkEdge) begin
            if (bus.lsbFirst) begin
                sreg_d = {bus.serialDataIn, sreg_q[WIDTH-1:1]};
            end else begin
                sreg_d = {sreg_q[WIDTH-2:0], bus.serialDataIn};
            end
            if (cnt_inc == CNTW'(WIDTH)) begin
                cnt_d   = '0;
                done_d  = 1'b1;
                valid_d = 1'b1;
            end else begin
                cnt_d   = cnt_inc;
                valid_d = 1'b0;
            end
        end else if (bus.frameStart) begin
            cnt_d   = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign bus.parallelDataOut = sreg_q;
    assign bus.serialDataOut   = bus.lsbFirst ? sreg_q[0] : sreg_q[WIDTH-1];
    assign bus.bitCount        = cnt_q;
    assign bus.frameDone       = done_q;
    assign bus.frameValid      = valid_q;
endmodule

// File: tb/tb_shiftregister_framed.sv
// Scoreboard bench for shiftregister_framed: WIDTH=8 and WIDTH=4 instances,
// directed stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_shiftregister_framed;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    shiftregister_framed_if #(.WIDTH(8)) a ();
    shiftregister_framed_if #(.WIDTH(4)) b ();

    shiftregister_framed #(.WIDTH(8)) u_w8 (.clk(clk), .reset(reset), .bus(a));
    shiftregister_framed #(.WIDTH(4)) u_w4 (.clk(clk), .reset(reset), .bus(b));

    typedef struct {
        int         tag;
        int         dut;
        string      name;
        logic [4:0] mask;  // pdo, cnt, done, valid, sdo
        logic [7:0] pdo;
        logic [3:0] cnt;
        logic       done;
        logic       valid;
        logic       sdo;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input string fld, input logic [7:0] got,
                       input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s.%s at cycle %0d: got 0x%0h, expected 0x%0h", nm, fld, cyc, got,
                     want);
        end
    endtask

    // Monitor: compares DUT outputs against the expectation tagged for this cycle
    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].tag <= cyc) begin
            exp_t       e;
            logic [7:0] g_pdo;
            logic [3:0] g_cnt;
            logic       g_done, g_valid, g_sdo;
            e = exp_q.pop_front();
            if (e.dut == 0) begin
                g_pdo = a.parallelDataOut; g_cnt = a.bitCount; g_done = a.frameDone;
                g_valid = a.frameValid; g_sdo = a.serialDataOut;
            end else begin
                g_pdo = {4'h0, b.parallelDataOut}; g_cnt = {1'b0, b.bitCount};
                g_done = b.frameDone; g_valid = b.frameValid; g_sdo = b.serialDataOut;
            end
            if (e.tag < cyc) begin
                n_checks++;
                n_fails++;
                $display("FAIL %s: stale expectation, tag %0d seen at cycle %0d", e.name,
                         e.tag, cyc);
            end else begin
                if (e.mask[4]) cmp(e.name, "parallelDataOut", g_pdo, e.pdo);
                if (e.mask[3]) cmp(e.name, "bitCount", {4'h0, g_cnt}, {4'h0, e.cnt});
                if (e.mask[2]) cmp(e.name, "frameDone", {7'h0, g_done}, {7'h0, e.done});
                if (e.mask[1]) cmp(e.name, "frameValid", {7'h0, g_valid}, {7'h0, e.valid});
                if (e.mask[0]) cmp(e.name, "serialDataOut", {7'h0, g_sdo}, {7'h0, e.sdo});
            end
        end
    end

    // Called just after a rising edge: drives one cycle and queues its post-edge result
    task automatic step(input int d, input logic rst, input logic ld, input logic ed,
                        input logic sdi, input logic lsb, input logic fs,
                        input logic [7:0] pdi, input string nm, input logic [4:0] m,
                        input logic [7:0] ep, input logic [3:0] ec, input logic edn,
                        input logic ev, input logic es);
        exp_t e;
        reset = rst;
        if (d == 0) begin
            a.parallelLoad = ld; a.peripheralClkEdge = ed; a.serialDataIn = sdi;
            a.lsbFirst = lsb; a.frameStart = fs; a.parallelDataIn = pdi;
        end else begin
            b.parallelLoad = ld; b.peripheralClkEdge = ed; b.serialDataIn = sdi;
            b.lsbFirst = lsb; b.frameStart = fs; b.parallelDataIn = pdi[3:0];
        end
        e = '{tag: cyc + 1, dut: d, name: nm, mask: m, pdo: ep, cnt: ec, done: edn,
              valid: ev, sdo: es};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    logic       msb_bits[8]  = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic [7:0] msb_pdo[8]   = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h14, 8'h29, 8'h52, 8'hA5};
    logic [3:0] cnt8[8]      = '{1, 2, 3, 4, 5, 6, 7, 0};
    logic [7:0] lsb_pdo[8]   = '{8'h1E, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00};
    logic       lsb_sdo[8]   = '{0, 1, 1, 1, 1, 0, 0, 0};
    logic [7:0] ab_pdo[8]    = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [3:0] ab_cnt[8]    = '{2, 3, 4, 5, 6, 7, 0, 1};
    logic [7:0] pre_pdo[5]   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
    logic [7:0] w4_pdo[8]    = '{8'h1, 8'h3, 8'h7, 8'hF, 8'hF, 8'hF, 8'hF, 8'hF};
    logic [3:0] w4_cnt[8]    = '{1, 2, 3, 0, 1, 2, 3, 0};
    logic       w4_done[8]   = '{0, 0, 0, 1, 0, 0, 0, 1};
    logic       w4_sdo[8]    = '{0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        a.parallelLoad = 0; a.peripheralClkEdge = 0; a.serialDataIn = 0; a.lsbFirst = 0;
        a.frameStart = 0; a.parallelDataIn = '0;
        b.parallelLoad = 0; b.peripheralClkEdge = 0; b.serialDataIn = 0; b.lsbFirst = 0;
        b.frameStart = 0; b.parallelDataIn = '0;
        @(posedge clk);
        #1;

        // Reset dominates a concurrent load of 0xFF
        for (int i = 0; i < 2; i++)
            step(0, 1, 1, 0, 0, 0, 0, 8'hFF, "reset", 5'b11111, 8'h00, 0, 0, 0, 0);

        // MSB-first receive of 0xA5, strobes three cycles apart
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 1, msb_bits[i], 0, 0, 8'h00, "msb_shift", 5'b11110, msb_pdo[i],
                 cnt8[i], i == 7, i == 7, 0);
            for (int k = 0; k < 2; k++)
                step(0, 0, 0, 0, 0, 0, 0, 8'h00, "msb_hold", 5'b11110, msb_pdo[i], cnt8[i],
                     0, i == 7, 0);
        end

        // LSB-first transmit of 0x3C, back-to-back strobes
        step(0, 0, 1, 0, 0, 1, 0, 8'h3C, "lsb_load", 5'b11111, 8'h3C, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 1, 0, 1, 0, 8'h00, "lsb_shift", 5'b11111, lsb_pdo[i], cnt8[i],
                 i == 7, i == 7, lsb_sdo[i]);
        step(0, 0, 0, 0, 0, 1, 0, 8'h00, "lsb_idle", 5'b11110, 8'h00, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 8'h00, "idle_fstart", 5'b11110, 8'h00, 0, 0, 0, 0);

        // Load wins over a same-cycle strobe, then register holds
        step(0, 0, 1, 1, 1, 0, 0, 8'h0F, "prio_load", 5'b11111, 8'h0F, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 8'h00, "prio_hold", 5'b11111, 8'h0F, 0, 0, 0, 0);

        // Mid-frame abort: 3 shifts, frameStart with a strobe, then 8 more strobes
        step(0, 0, 0, 1, 1, 0, 0, 8'h00, "abort_pre", 5'b11110, 8'h1F, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 8'h00, "abort_pre", 5'b11110, 8'h3F, 2, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 8'h00, "abort_pre", 5'b11110, 8'h7F, 3, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 1, 8'h00, "abort_fs", 5'b11110, 8'hFF, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 1, 0, 0, 0, 8'h00, "abort_post", 5'b11110, ab_pdo[i], ab_cnt[i],
                 i == 6, i == 6, 0);

        // New frame, 5 shifts, then reset with load and strobe asserted
        step(0, 0, 0, 0, 0, 0, 1, 8'h00, "frame_start", 5'b11110, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 1, 1, 0, 0, 8'h00, "pre_reset", 5'b11110, pre_pdo[i], 4'(i + 1), 0,
                 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 8'hAA, "mid_reset", 5'b11111, 8'h00, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 8'h00, "post_reset", 5'b11111, 8'h00, 0, 0, 0, 0);

        // WIDTH=4 instance: 8 consecutive strobes of 1, two full frames
        for (int i = 0; i < 8; i++)
            step(1, 0, 0, 1, 1, 0, 0, 8'h00, "w4_shift", 5'b11111, w4_pdo[i], w4_cnt[i],
                 w4_done[i], w4_done[i], w4_sdo[i]);
        step(1, 0, 0, 0, 0, 0, 0, 8'h00, "w4_idle", 5'b11111, 8'h0F, 0, 0, 1, 1);

        @(posedge clk);
        @(posedge clk);
        #1;
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            n_fails++;
            $display("FAIL %s: expectation tag %0d never checked", e.name, e.tag);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
